eth_txarb: RTL and testbench
============================

Name: eth_txarb

Overview:
- Frame-aware round-robin arbiter merging two 74-bit Ethernet TX FIFOs (FWFT style) into one FIFO-like read port for the 10G MAC TX path.
- Locks its grant to one source from the first word of a frame until the tlast word is consumed. Frames never interleave.
- Discards stray null words (tkeep==0) at frame boundaries.
- Keeps per-source frame and drop counters.

Parameters:
- MAX_WORDS, 1024: frame length in words beyond which err_oversize is set.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk156  input  1  TX clock; all logic is in this domain.
- rst_n  input  1  asynchronous active-low reset.
- arb_en  input  1  when low, the current frame finishes, then no new grants are issued.
- fifo0_rd_en  output  1  read strobe to source 0.
- fifo0_dout  input  74  source 0 word: [73:66] tkeep, [65:2] tdata, [1] tlast, [0] tuser.
- fifo0_empty  input  1  source 0 empty.
- fifo1_rd_en  output  1  read strobe to source 1.
- fifo1_dout  input  74  source 1 word, same layout as source 0.
- fifo1_empty  input  1  source 1 empty.
- rd_en  input  1  downstream read strobe.
- dout  output  74  merged word.
- empty  output  1  merged empty.
- sel  output  1  registered current or last grant (0 = source 0, 1 = source 1).
- busy  output  1  high when in state GRANT0 or GRANT1.
- frame_cnt0  output  CNT_W  frames forwarded from source 0.
- frame_cnt1  output  CNT_W  frames forwarded from source 1.
- drop_cnt0  output  CNT_W  null words discarded from source 0.
- drop_cnt1  output  CNT_W  null words discarded from source 1.
- err_oversize  output  1  sticky; set when a frame exceeds MAX_WORDS.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, prio=0, sel=0, busy=0, word_cnt=0.
  - All counters 0, err_oversize=0.
  - empty=1, dout=0, fifo0_rd_en=0, fifo1_rd_en=0.
- Reset in the middle of a frame abandons it immediately. No further source reads until a new grant.
- Source n is a candidate when !fifon_empty, tkeep!=0 and arb_en=1.
- State IDLE:
  - empty=1, dout=0. rd_en is ignored.
  - One candidate: go to GRANTn next cycle, sel<=n.
  - Two candidates: grant source prio.
  - Non-candidate source showing a null word (!empty, tkeep==0): pulse its rd_en for 1 cycle and increment its drop_cnt. This runs even when arb_en=0.
  - Draining one source and granting the other may happen in the same cycle.
- State GRANTn:
  - dout=fifon_dout, empty=fifon_empty, combinational pass-through.
  - fifon_rd_en = rd_en & !fifon_empty. The other source's rd_en=0.
  - A beat occurs when rd_en & !empty. Each beat increments word_cnt.
  - Beat with tlast=1: next state IDLE, frame_cntn++, prio <= ~n, word_cnt<=0.
  - rd_en while empty: no beat, no read, no state change.
  - arb_en going low mid-frame: no effect until tlast.
  - Null words inside a frame are forwarded unchanged.
- Oversize: when word_cnt reaches MAX_WORDS with no tlast beat, set err_oversize (sticky). The grant is held; the frame is not truncated. word_cnt saturates at MAX_WORDS.
- Latency:
  - Grant issued 1 cycle after a candidate appears in IDLE.
  - Minimum 1 IDLE cycle between consecutive frames.
  - The data path has no added latency.
- Counters wrap at 2^CNT_W.
- tuser is forwarded transparently and does not influence arbitration.

Test Plan:
- Reset then idle, both sources empty -> empty=1, both rd_en=0, all counters 0, sel=0.
- Source 0 only: 3-word frame (tkeep=FF, FF, 0F; tlast on word 3), rd_en held high.
  - Grant in cycle 1; 3 beats; back to IDLE.
  - frame_cnt0=1, sel=0, fifo1_rd_en never asserted.
- Both sources hold 2-frame queues, rd_en=1 continuously.
  - Grant order 0,1,0,1.
  - frame_cnt0=2, frame_cnt1=2; no word interleaving inside a frame.
- Source 1 presents a tkeep=00 word at IDLE while source 0 starts a frame.
  - Same cycle: fifo1_rd_en pulses once, drop_cnt1=1, grant goes to source 0.
- MAX_WORDS=4 with a 6-word frame -> err_oversize=1 after the 4th beat, remains 1; all 6 words forwarded; frame_cnt increments.
- rst_n low after word 2 of a 5-word frame -> empty=1, state IDLE, no further rd_en pulses; after release, next candidate is granted normally.

Source files
------------

// File: rtl/eth_txarb.sv
// Frame-aware round-robin arbiter merging two FWFT Ethernet TX FIFOs into one
// FWFT read port; grants are held from the first word until the tlast beat.
module eth_txarb #(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 32
) (
  input  logic             clk156,
  input  logic             rst_n,
  input  logic             arb_en,
  output logic             fifo0_rd_en,
  input  logic [73:0]      fifo0_dout,
  input  logic             fifo0_empty,
  output logic             fifo1_rd_en,
  input  logic [73:0]      fifo1_dout,
  input  logic             fifo1_empty,
  input  logic             rd_en,
  output logic [73:0]      dout,
  output logic             empty,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt0,
  output logic [CNT_W-1:0] frame_cnt1,
  output logic [CNT_W-1:0] drop_cnt0,
  output logic [CNT_W-1:0] drop_cnt1,
  output logic             err_oversize
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam logic [WC_W-1:0] MAX_WC = WC_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic            sel_q, sel_d;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic            err_q, err_d;

  logic [1:0][73:0] src_dout;
  logic [1:0]       src_empty;
  logic [1:0]       src_cand;
  logic [1:0]       src_null;
  logic [1:0]       src_rd;
  logic [1:0]       frame_inc;
  logic [1:0]       drop_inc;
  logic             cur;

  assign src_dout  = {fifo1_dout, fifo0_dout};
  assign src_empty = {fifo1_empty, fifo0_empty};

  // Per-source qualification and statistics; a null word never qualifies.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [CNT_W-1:0] frame_cnt_q;
      logic [CNT_W-1:0] drop_cnt_q;

      assign src_null[gi] = !src_empty[gi] && (src_dout[gi][73:66] == 8'h00);
      assign src_cand[gi] = !src_empty[gi] && (src_dout[gi][73:66] != 8'h00) && arb_en;

      always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
          frame_cnt_q <= '0;
          drop_cnt_q  <= '0;
        end else begin
          if (frame_inc[gi]) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
          if (drop_inc[gi])  drop_cnt_q  <= drop_cnt_q + CNT_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      sel_q      <= 1'b0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      sel_q      <= sel_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    sel_d      = sel_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    src_rd     = '0;
    frame_inc  = '0;
    drop_inc   = '0;
    dout       = '0;
    empty      = 1'b1;
    cur        = (state_q == GRANT1);

    case (state_q)
      IDLE: begin
        // Null words are flushed regardless of arb_en so they cannot block a source.
        src_rd   = src_null;
        drop_inc = src_null;
        if (src_cand[0] && (!src_cand[1] || !prio_q)) begin
          state_d = GRANT0;
          sel_d   = 1'b0;
        end else if (src_cand[1]) begin
          state_d = GRANT1;
          sel_d   = 1'b1;
        end
      end

      GRANT0, GRANT1: begin
        dout        = src_dout[cur];
        empty       = src_empty[cur];
        src_rd[cur] = rd_en && !src_empty[cur];
        if (src_rd[cur]) begin
          if (src_dout[cur][1]) begin
            state_d        = IDLE;
            frame_inc[cur] = 1'b1;
            prio_d         = ~cur;
            word_cnt_d     = '0;
          end else begin
            if (word_cnt_q != MAX_WC) word_cnt_d = word_cnt_q + WC_W'(1);
            // Oversize is flagged but the frame is still forwarded intact.
            if (word_cnt_d == MAX_WC) err_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign fifo0_rd_en  = src_rd[0];
  assign fifo1_rd_en  = src_rd[1];
  assign sel          = sel_q;
  assign busy         = (state_q == GRANT0) || (state_q == GRANT1);
  assign err_oversize = err_q;
  assign frame_cnt0   = g_src[0].frame_cnt_q;
  assign frame_cnt1   = g_src[1].frame_cnt_q;
  assign drop_cnt0    = g_src[0].drop_cnt_q;
  assign drop_cnt1    = g_src[1].drop_cnt_q;

endmodule

// File: tb/tb_eth_txarb.sv
// Scoreboard bench for eth_txarb: two queue-modelled FWFT sources, expected
// merged words queued at stimulus time and compared on every downstream beat.
module tb_eth_txarb;
  localparam int CNT_W = 32;

  logic             clk156 = 1'b0;
  logic             rst_n;
  logic             arb_en;
  logic             fifo0_rd_en, fifo1_rd_en;
  logic [73:0]      fifo0_dout, fifo1_dout;
  logic             fifo0_empty, fifo1_empty;
  logic             rd_en;
  logic [73:0]      dout;
  logic             empty, sel, busy, err_oversize;
  logic [CNT_W-1:0] frame_cnt0, frame_cnt1, drop_cnt0, drop_cnt1;

  always #5 clk156 = ~clk156;

  eth_txarb #(.MAX_WORDS(4), .CNT_W(CNT_W)) dut (
    .clk156      (clk156),
    .rst_n       (rst_n),
    .arb_en      (arb_en),
    .fifo0_rd_en (fifo0_rd_en),
    .fifo0_dout  (fifo0_dout),
    .fifo0_empty (fifo0_empty),
    .fifo1_rd_en (fifo1_rd_en),
    .fifo1_dout  (fifo1_dout),
    .fifo1_empty (fifo1_empty),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .sel         (sel),
    .busy        (busy),
    .frame_cnt0  (frame_cnt0),
    .frame_cnt1  (frame_cnt1),
    .drop_cnt0   (drop_cnt0),
    .drop_cnt1   (drop_cnt1),
    .err_oversize(err_oversize)
  );

  logic [73:0] q0[$];
  logic [73:0] q1[$];
  logic [73:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          rd0_pulses = 0;
  int          rd1_pulses = 0;
  logic        r0, r1, beat_seen;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [73:0] mk(input logic [7:0] k, input logic [63:0] d,
                                     input logic l, input logic u);
    return {k, d, l, u};
  endfunction

  task automatic refresh();
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
    fifo0_dout  = (q0.size() != 0) ? q0[0] : '0;
    fifo1_dout  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // Push an n-word frame (tlast on the final word) to a source and optionally to the scoreboard.
  task automatic push_frame(input int src, input int n, input logic [63:0] base, input bit to_exp);
    logic [73:0] w;
    for (int i = 0; i < n; i++) begin
      w = mk((i == n - 1) ? 8'h0F : 8'hFF, base + 64'(i), (i == n - 1), i[0]);
      if (src == 0) q0.push_back(w); else q1.push_back(w);
      if (to_exp) exp_q.push_back(w);
    end
    refresh();
  endtask

  task automatic tick();
    @(negedge clk156);
    r0 = fifo0_rd_en;
    r1 = fifo1_rd_en;
    beat_seen = 1'b0;
    if (r0) rd0_pulses++;
    if (r1) rd1_pulses++;
    if (rd_en && !empty) begin
      beat_seen = 1'b1;
      $display("beat sel=%0d word=%h", sel, dout);
      if (exp_q.size() == 0) check("exp_q_nonempty", 128'(exp_q.size()), 128'(1));
      else check("beat_data", 128'(dout), 128'(exp_q.pop_front()));
    end
    @(posedge clk156);
    #1;
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    refresh();
  endtask

  task automatic run_frames(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int nb;
    rst_n = 1'b0; arb_en = 1'b1; rd_en = 1'b0;
    refresh();

    // Reset state
    repeat (2) @(posedge clk156);
    #1;
    check("rst_empty", 128'(empty), 128'(1));
    check("rst_dout", 128'(dout), 128'(0));
    check("rst_rd0", 128'(fifo0_rd_en), 128'(0));
    check("rst_rd1", 128'(fifo1_rd_en), 128'(0));
    check("rst_sel", 128'(sel), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_cnts", 128'({frame_cnt0, frame_cnt1, drop_cnt0, drop_cnt1}), 128'(0));
    check("rst_err", 128'(err_oversize), 128'(0));
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_empty", 128'(empty), 128'(1));
    check("idle_no_reads", 128'(rd0_pulses + rd1_pulses), 128'(0));

    // Source 0 alone: 3-word frame
    rd_en = 1'b1;
    rd1_pulses = 0;
    push_frame(0, 3, 64'h1000, 1'b1);
    check("s0_idle_before_grant", 128'(busy), 128'(0));
    tick();
    check("s0_no_beat_in_idle", 128'(beat_seen), 128'(0));
    check("s0_grant_busy", 128'(busy), 128'(1));
    check("s0_grant_sel", 128'(sel), 128'(0));
    run_frames(50);
    check("s0_back_idle", 128'(busy), 128'(0));
    check("s0_frame_cnt0", 128'(frame_cnt0), 128'(1));
    check("s0_sel", 128'(sel), 128'(0));
    check("s0_no_rd1", 128'(rd1_pulses), 128'(0));

    // Both sources, 2 frames each: round-robin 0,1,0,1 from a fresh reset
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_frame(0, 2 + i, 64'hA000 + 64'(i * 16), 1'b0);
      push_frame(1, 2, 64'hB000 + 64'(i * 16), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2 + i; j++) exp_q.push_back(q0[(i == 0) ? j : 2 + j]);
      for (int j = 0; j < 2; j++) exp_q.push_back(q1[2 * i + j]);
    end
    run_frames(100);
    check("rr_frame_cnt0", 128'(frame_cnt0), 128'(2));
    check("rr_frame_cnt1", 128'(frame_cnt1), 128'(2));
    check("rr_drops", 128'({drop_cnt0, drop_cnt1}), 128'(0));

    // Null word on source 1 drained in the same cycle source 0 is granted
    rd1_pulses = 0;
    q1.push_back(mk(8'h00, 64'hDEAD, 1'b0, 1'b0));
    push_frame(0, 2, 64'hC000, 1'b1);
    tick();
    check("null_pulse_rd1", 128'(r1), 128'(1));
    check("null_no_rd0", 128'(r0), 128'(0));
    check("null_grant_sel", 128'(sel), 128'(0));
    check("null_grant_busy", 128'(busy), 128'(1));
    check("null_drop_cnt1", 128'(drop_cnt1), 128'(1));
    run_frames(50);
    check("null_single_pulse", 128'(rd1_pulses), 128'(1));
    check("null_frame_cnt0", 128'(frame_cnt0), 128'(3));

    // arb_en low holds off a new grant
    arb_en = 1'b0;
    rd0_pulses = 0;
    push_frame(0, 2, 64'hD000, 1'b1);
    repeat (3) tick();
    check("dis_no_grant", 128'(busy), 128'(0));
    check("dis_no_read", 128'(rd0_pulses), 128'(0));
    arb_en = 1'b1;
    run_frames(50);
    check("dis_frame_cnt0", 128'(frame_cnt0), 128'(4));

    // Oversize: 6-word frame with MAX_WORDS=4; arb_en dropped mid-frame has no effect
    push_frame(0, 6, 64'hE000, 1'b1);
    nb = 0;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
      tick();
      if (beat_seen) begin
        nb++;
        if (nb == 2) arb_en = 1'b0;
        check("ovs_err_after_beat", 128'(err_oversize), 128'(nb >= 4));
      end
    end
    check("ovs_all_words", 128'(nb), 128'(6));
    arb_en = 1'b1;
    repeat (2) tick();
    check("ovs_err_sticky", 128'(err_oversize), 128'(1));
    check("ovs_frame_cnt0", 128'(frame_cnt0), 128'(5));

    // Reset after word 2 of a 5-word frame
    push_frame(0, 5, 64'hF000, 1'b0);
    exp_q.push_back(q0[0]);
    exp_q.push_back(q0[1]);
    nb = 0;
    for (int n = 0; n < 20 && nb < 2; n++) begin
      tick();
      if (beat_seen) nb++;
    end
    check("mid_two_beats", 128'(nb), 128'(2));
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 128'(empty), 128'(1));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_err", 128'(err_oversize), 128'(0));
    rd0_pulses = 0;
    repeat (3) tick();
    check("mid_rst_no_reads", 128'(rd0_pulses), 128'(0));
    q0.delete();
    push_frame(1, 2, 64'h5000, 1'b1);
    rst_n = 1'b1;
    check("mid_idle_after_rel", 128'(busy), 128'(0));
    tick();
    check("mid_regrant_sel", 128'(sel), 128'(1));
    run_frames(50);
    check("mid_frame_cnt1", 128'(frame_cnt1), 128'(1));
    check("mid_frame_cnt0", 128'(frame_cnt0), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
